// File: rtl/radiant_event_sequencer.sv
// Event sequencer: accepts a trigger, emits a header, runs N readout sequences under a
// watchdog, hands the event to DMA and pulses done.
module radiant_event_sequencer #(
  parameter int unsigned NSEQ_W    = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              trig_i,
  input  logic [15:0]       trig_info_i,
  input  logic [NSEQ_W-1:0] nseq_i,
  input  logic [7:0]        fifo_free_i,
  output logic              readout_start_o,
  input  logic              readout_seq_done_i,
  output logic              hdr_valid_o,
  input  logic              hdr_ready_i,
  output logic [31:0]       hdr_data_o,
  output logic              dma_req_o,
  input  logic              dma_ack_i,
  input  logic              dma_done_i,
  output logic              readout_done_o,
  output logic              readout_full_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic [15:0]       dropped_o
);

  localparam int unsigned CmpW = (NSEQ_W > 8) ? NSEQ_W : 8;

  typedef enum logic [2:0] {
    StIdle, StHeader, StStart, StWait, StDmaReq, StDmaWait, StDone
  } state_e;

  state_e                r_state, w_state_nxt;
  logic [15:0]           r_trig_info, r_evt_cnt, r_dropped;
  logic [NSEQ_W-1:0]     r_nseq, r_seq_cnt;
  logic [NSEQ_W-1:0]     w_nseq_eff, w_seq_cnt_inc;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic                  r_full, r_terr;
  logic                  w_wdog_exp, w_trig_drop;

  assign w_nseq_eff    = (nseq_i == '0) ? NSEQ_W'(1) : nseq_i;
  assign w_seq_cnt_inc = r_seq_cnt + NSEQ_W'(1);
  // Counter holds k-1 in the k-th WAIT cycle, so this fires on cycle 2^TIMEOUT_W-1.
  assign w_wdog_exp    = (r_wdog == {{(TIMEOUT_W-1){1'b1}}, 1'b0});
  assign w_trig_drop   = trig_i && (r_state != StIdle);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (trig_i) w_state_nxt = StHeader;
      StHeader:  if (hdr_ready_i) w_state_nxt = StStart;
      StStart:   w_state_nxt = StWait;
      StWait: begin
        if (readout_seq_done_i) begin
          w_state_nxt = (w_seq_cnt_inc == r_nseq) ? StDmaReq : StStart;
        end else if (w_wdog_exp) begin
          w_state_nxt = StDmaReq;
        end
      end
      StDmaReq:  if (dma_ack_i) w_state_nxt = dma_done_i ? StDone : StDmaWait;
      StDmaWait: if (dma_done_i) w_state_nxt = StDone;
      StDone:    w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state     <= StIdle;
      r_trig_info <= '0;
      r_evt_cnt   <= '0;
      r_dropped   <= '0;
      r_nseq      <= '0;
      r_seq_cnt   <= '0;
      r_wdog      <= '0;
      r_full      <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= CmpW'(fifo_free_i) < CmpW'(w_nseq_eff);
      if (r_state == StIdle && trig_i) begin
        r_trig_info <= trig_info_i;
        r_nseq      <= w_nseq_eff;
        r_seq_cnt   <= '0;
      end
      if (r_state == StHeader && hdr_ready_i) r_evt_cnt <= r_evt_cnt + 16'd1;
      if (r_state == StStart) begin
        r_wdog <= '0;
      end else if (r_state == StWait) begin
        r_wdog <= r_wdog + TIMEOUT_W'(1);
      end
      if (r_state == StWait && readout_seq_done_i) r_seq_cnt <= w_seq_cnt_inc;
      if (r_state == StWait && !readout_seq_done_i && w_wdog_exp) r_terr <= 1'b1;
      if (w_trig_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
    end
  end

  assign readout_start_o = (r_state == StStart);
  assign hdr_valid_o     = (r_state == StHeader);
  assign hdr_data_o      = {r_evt_cnt, r_trig_info};
  assign dma_req_o       = (r_state == StDmaReq);
  assign readout_done_o  = (r_state == StDone);
  assign readout_full_o  = r_full;
  assign busy_o          = (r_state != StIdle);
  assign timeout_err_o   = r_terr;
  assign dropped_o       = r_dropped;

endmodule

// File: tb/tb_radiant_event_sequencer.sv
// Randomized bench for radiant_event_sequencer: stimulus pushes expected headers and event
// outcomes into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_radiant_event_sequencer;

  localparam int unsigned NSEQ_W    = 4;
  localparam int unsigned TIMEOUT_W = 6;

  logic              sys_clk_i = 1'b0;
  logic              sys_rst_i;
  logic              trig_i;
  logic [15:0]       trig_info_i;
  logic [NSEQ_W-1:0] nseq_i;
  logic [7:0]        fifo_free_i;
  logic              readout_start_o;
  logic              readout_seq_done_i;
  logic              hdr_valid_o;
  logic              hdr_ready_i;
  logic [31:0]       hdr_data_o;
  logic              dma_req_o;
  logic              dma_ack_i;
  logic              dma_done_i;
  logic              readout_done_o;
  logic              readout_full_o;
  logic              busy_o;
  logic              timeout_err_o;
  logic [15:0]       dropped_o;

  radiant_event_sequencer #(
    .NSEQ_W   (NSEQ_W),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .sys_clk_i         (sys_clk_i),
    .sys_rst_i         (sys_rst_i),
    .trig_i            (trig_i),
    .trig_info_i       (trig_info_i),
    .nseq_i            (nseq_i),
    .fifo_free_i       (fifo_free_i),
    .readout_start_o   (readout_start_o),
    .readout_seq_done_i(readout_seq_done_i),
    .hdr_valid_o       (hdr_valid_o),
    .hdr_ready_i       (hdr_ready_i),
    .hdr_data_o        (hdr_data_o),
    .dma_req_o         (dma_req_o),
    .dma_ack_i         (dma_ack_i),
    .dma_done_i        (dma_done_i),
    .readout_done_o    (readout_done_o),
    .readout_full_o    (readout_full_o),
    .busy_o            (busy_o),
    .timeout_err_o     (timeout_err_o),
    .dropped_o         (dropped_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    int starts;
    bit tmo;
    bit terr;
  } evt_t;

  evt_t        exp_evt[$];
  logic [31:0] exp_hdr[$];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_evt  = 16'd0;
  logic [15:0] m_drop = 16'd0;
  bit          m_terr = 1'b0;

  // Responder knobs
  int g_seq_delay = 0;
  bit g_no_done   = 1'b0;
  bit g_dma_fast  = 1'b0;
  bit g_hdr_rand  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Readout sequence responder: one done pulse per start, after a delay in WAIT cycles.
  initial begin
    readout_seq_done_i = 1'b0;
    forever begin
      @(posedge sys_clk_i); #1;
      while (readout_start_o && !g_no_done) begin
        int d;
        d = (g_seq_delay != 0) ? g_seq_delay : int'($urandom_range(1, 12));
        repeat (d) begin @(posedge sys_clk_i); #1; end
        readout_seq_done_i = 1'b1;
        @(posedge sys_clk_i); #1;
        readout_seq_done_i = 1'b0;
      end
    end
  end

  // DMA responder
  initial begin
    dma_ack_i  = 1'b0;
    dma_done_i = 1'b0;
    forever begin
      @(posedge sys_clk_i); #1;
      if (dma_req_o) begin
        int a, dd;
        bit same;
        a    = g_dma_fast ? 0 : int'($urandom_range(0, 3));
        same = g_dma_fast ? 1'b1 : 1'($urandom_range(0, 1));
        dd   = int'($urandom_range(0, 3));
        repeat (a) begin @(posedge sys_clk_i); #1; end
        dma_ack_i  = 1'b1;
        dma_done_i = same;
        @(posedge sys_clk_i); #1;
        dma_ack_i  = 1'b0;
        dma_done_i = 1'b0;
        if (!same) begin
          repeat (dd) begin @(posedge sys_clk_i); #1; end
          dma_done_i = 1'b1;
          @(posedge sys_clk_i); #1;
          dma_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    hdr_ready_i = 1'b1;
    forever begin
      @(posedge sys_clk_i); #1;
      hdr_ready_i = g_hdr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    int          n_starts, n_dma, gap;
    bit          prev_dma, hdr_hold;
    logic [31:0] hdr_prev;
    evt_t        e;
    n_starts = 0; n_dma = 0; gap = 0; prev_dma = 0; hdr_hold = 0; hdr_prev = '0;
    forever begin
      @(negedge sys_clk_i);
      if (sys_rst_i) begin
        n_starts = 0; n_dma = 0; gap = 0; prev_dma = 0; hdr_hold = 0;
      end else begin
        gap++;
        if (readout_start_o) begin
          n_starts++;
          gap = 0;
        end
        if (dma_req_o && !prev_dma) begin
          n_dma++;
          if (exp_evt.size() == 0) begin
            check("dma_req_unexpected", 1, 0);
          end else if (exp_evt[0].tmo) begin
            check("wdog_gap", gap, 2 ** TIMEOUT_W);
            check("timeout_err_at_dma", timeout_err_o, 1);
          end
        end
        prev_dma = dma_req_o;
        if (hdr_valid_o) begin
          if (hdr_hold) check("hdr_stable", hdr_data_o, hdr_prev);
          hdr_prev = hdr_data_o;
          if (hdr_ready_i) begin
            hdr_hold = 0;
            if (exp_hdr.size() == 0) check("hdr_unexpected", 1, 0);
            else check("hdr_data", hdr_data_o, exp_hdr.pop_front());
          end else begin
            hdr_hold = 1;
          end
        end
        if (readout_done_o) begin
          if (exp_evt.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            e = exp_evt.pop_front();
            check("start_count", n_starts, e.starts);
            check("dma_req_count", n_dma, 1);
            check("timeout_err", timeout_err_o, e.terr);
          end
          n_starts = 0;
          n_dma    = 0;
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {readout_start_o, hdr_valid_o, hdr_data_o, dma_req_o, readout_done_o,
                 readout_full_o, busy_o, timeout_err_o, dropped_o}, 0);
  endtask

  task automatic run_event(input logic [15:0] info, input logic [NSEQ_W-1:0] ns,
                           input bit no_done, input int ndrop, output int lat);
    evt_t e;
    int   cyc, drops;
    e.starts = (no_done || ns == 0) ? 1 : int'(ns);
    e.tmo    = no_done;
    m_terr   = m_terr | no_done;
    e.terr   = m_terr;
    exp_hdr.push_back({m_evt, info});
    m_evt = m_evt + 16'd1;
    exp_evt.push_back(e);
    g_no_done   = no_done;
    nseq_i      = ns;
    trig_info_i = info;
    trig_i      = 1'b1;
    @(posedge sys_clk_i); #1;
    trig_i      = 1'b0;
    trig_info_i = 16'($urandom);
    cyc = 0;
    drops = 0;
    while (!readout_done_o && cyc < 2000) begin
      if (drops < ndrop && busy_o && (cyc % 2 == 1)) begin
        trig_i = 1'b1;
        drops++;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      @(posedge sys_clk_i); #1;
      trig_i = 1'b0;
      cyc++;
    end
    if (cyc >= 2000) check("event_timeout", 0, 1);
    lat = cyc + 1;
    check("dropped", dropped_o, m_drop);
    @(posedge sys_clk_i); #1;
    check("idle_after_done", busy_o, 0);
  endtask

  initial begin
    int lat, ne, cyc;
    sys_rst_i   = 1'b1;
    trig_i      = 1'b0;
    trig_info_i = '0;
    nseq_i      = '0;
    fifo_free_i = 8'd255;
    repeat (3) @(posedge sys_clk_i);
    #1;
    sys_rst_i = 1'b0;
    check_all_zero("reset_outputs");

    // FIFO-full flag: directed corners then random
    nseq_i = 0; fifo_free_i = 0;
    @(posedge sys_clk_i); #1;
    check("full_nseq0_free0", readout_full_o, 1);
    fifo_free_i = 1;
    @(posedge sys_clk_i); #1;
    check("full_nseq0_free1", readout_full_o, 0);
    for (int i = 0; i < 16; i++) begin
      nseq_i      = NSEQ_W'($urandom);
      fifo_free_i = 8'($urandom_range(0, 20));
      ne = (nseq_i == 0) ? 1 : int'(nseq_i);
      @(posedge sys_clk_i); #1;
      check("full_random", readout_full_o, (int'(fifo_free_i) < ne) ? 1 : 0);
    end
    fifo_free_i = 8'd255;

    // Three sequences, done 10 cycles after each start; then a second event with drops
    g_seq_delay = 10;
    run_event(16'h0015, 3, 0, 0, lat);
    run_event(16'h0015, 3, 0, 4, lat);
    check("dropped_four", dropped_o, 16'd4);

    // Minimum latency with same-cycle ack/done, for nseq=1 and nseq=0
    g_seq_delay = 1;
    g_dma_fast  = 1;
    run_event(16'($urandom), 1, 0, 0, lat);
    check("min_latency_nseq1", lat, 5);
    run_event(16'($urandom), 0, 0, 0, lat);
    check("min_latency_nseq0", lat, 5);

    // Randomized events
    g_seq_delay = 0;
    g_dma_fast  = 0;
    g_hdr_rand  = 1;
    for (int i = 0; i < 12; i++) begin
      run_event(16'($urandom), NSEQ_W'($urandom), 0, int'($urandom_range(0, 3)), lat);
      repeat ($urandom_range(0, 3)) @(posedge sys_clk_i);
      #1;
    end

    // Watchdog expiry, then an ordinary event to confirm the error is sticky
    run_event(16'($urandom), 2, 1, 0, lat);
    check("timeout_sticky_idle", timeout_err_o, 1);
    run_event(16'($urandom), 2, 0, 1, lat);

    // Reset while waiting on a readout sequence
    g_no_done   = 1;
    g_hdr_rand  = 0;
    exp_hdr.push_back({m_evt, 16'h00AB});
    nseq_i      = 2;
    trig_info_i = 16'h00AB;
    trig_i      = 1'b1;
    @(posedge sys_clk_i); #1;
    trig_i = 1'b0;
    cyc = 0;
    while (!readout_start_o && cyc < 50) begin
      @(posedge sys_clk_i); #1;
      cyc++;
    end
    check("reset_test_reached_start", readout_start_o, 1);
    repeat (3) @(posedge sys_clk_i);
    #1;
    sys_rst_i = 1'b1;
    @(posedge sys_clk_i); #1;
    sys_rst_i = 1'b0;
    check_all_zero("midevent_reset_outputs");
    check("hdr_consumed_before_reset", exp_hdr.size(), 0);
    exp_hdr.delete();
    exp_evt.delete();
    m_evt  = 16'd0;
    m_drop = 16'd0;
    m_terr = 1'b0;
    repeat (80) @(posedge sys_clk_i);
    #1;
    check("no_done_after_reset", busy_o, 0);
    run_event(16'h0042, 2, 0, 0, lat);

    repeat (5) @(posedge sys_clk_i);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
